// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// TPL DAC start-up sequencer: arm -> optional external sync edge -> delay -> RUN.
// Optional `TPL_DAC_SYNC_CNT_EN adds a saturating sync_count output.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
  parameter int NUM_CHANNELS  = 2,
  parameter int DELAY_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm_req,
  input  logic                     external_sync_en,
  input  logic                     external_sync,
  input  logic [DELAY_WIDTH-1:0]   sync_delay_cfg,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cfg,
  input  logic                     timeout_clr,
  input  logic                     link_ready,
  input  logic [NUM_CHANNELS-1:0]  enable_in,
  output logic                     datapath_en,
  output logic [NUM_CHANNELS-1:0]  dac_valid,
  output logic                     start_pulse,
  output logic                     sync_armed,
  output logic                     timeout_err,
  output logic [1:0]               state
`ifdef TPL_DAC_SYNC_CNT_EN
  ,
  output logic [31:0]              sync_count
`endif
);

  // state | meaning
  // IDLE  | datapath gated, waiting for arm_req
  // ARMED | waiting for external_sync rising edge, timeout running
  // DELAY | counting down sync_delay_cfg before release
  // RUN   | datapath released, dac_valid follows enables
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [TIMEOUT_WIDTH:0] TMO_ONE = (TIMEOUT_WIDTH+1)'(1);

  state_t                    state_q, state_d;
  logic                      ext_q;
  logic                      ext_rise;
  logic [DELAY_WIDTH-1:0]    dly_q, dly_d;
  logic [TIMEOUT_WIDTH-1:0]  tmo_q, tmo_d;
  logic                      tmo_hit;
  logic                      start_q, start_d;
  logic                      err_q, err_d;
  logic [NUM_CHANNELS-1:0]   valid_q, valid_d;
  state_t                    arm_target;

  assign ext_rise   = external_sync & ~ext_q;
  assign arm_target = external_sync_en ? ST_ARMED : ST_DELAY;
  // Timeout fires on the cfg-th ARMED cycle, counting the entry cycle as the first.
  assign tmo_hit    = (timeout_cfg != '0) &&
                      (({1'b0, tmo_q} + TMO_ONE) == {1'b0, timeout_cfg});

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    if (timeout_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm_req) state_d = arm_target;
      end
      ST_ARMED: begin
        tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
        if (arm_req) tmo_d = '0;
        if (ext_rise) begin
          state_d = ST_DELAY;
        end else if (!arm_req && tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_DELAY: begin
        if (arm_req)           state_d = arm_target;
        else if (dly_q == '0)  state_d = ST_RUN;
        else                   dly_d   = dly_q - DELAY_WIDTH'(1);
      end
      ST_RUN: begin
        if (arm_req) state_d = arm_target;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counters reload on every entry, including a re-arm into the same state.
    if (state_d == ST_DELAY && (state_q != ST_DELAY || arm_req)) dly_d = sync_delay_cfg;
    if (state_d == ST_ARMED && state_q != ST_ARMED)             tmo_d = '0;
  end

  always_comb begin
    start_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    valid_d = '0;
    // Requiring RUN in both current and next state gates dac_valid the cycle after a re-arm.
    if (state_q == ST_RUN && state_d == ST_RUN)
      valid_d = enable_in & {NUM_CHANNELS{link_ready}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ext_q   <= 1'b0;
      dly_q   <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= external_sync;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign state       = state_q;
  assign datapath_en = (state_q == ST_RUN);
  assign sync_armed  = (state_q == ST_ARMED);
  assign start_pulse = start_q;
  assign timeout_err = err_q;
  assign dac_valid   = valid_q;

`ifdef TPL_DAC_SYNC_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_d && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sync_count = cnt_q;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Directed bench for ad_ip_jesd204_tpl_dac_sync_ctrl; checks cycle-exact sequencing.
// Define TPL_DAC_SYNC_CNT_EN to also check sync_count.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_req;
  logic        external_sync_en;
  logic        external_sync;
  logic [7:0]  sync_delay_cfg;
  logic [15:0] timeout_cfg;
  logic        timeout_clr;
  logic        link_ready;
  logic [1:0]  enable_in;
  logic        datapath_en;
  logic [1:0]  dac_valid;
  logic        start_pulse;
  logic        sync_armed;
  logic        timeout_err;
  logic [1:0]  state;
`ifdef TPL_DAC_SYNC_CNT_EN
  logic [31:0] sync_count;
`endif

  int n_chk = 0;
  int n_bad = 0;

  ad_ip_jesd204_tpl_dac_sync_ctrl #(
    .NUM_CHANNELS(2), .DELAY_WIDTH(8), .TIMEOUT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .arm_req(arm_req),
    .external_sync_en(external_sync_en), .external_sync(external_sync),
    .sync_delay_cfg(sync_delay_cfg), .timeout_cfg(timeout_cfg),
    .timeout_clr(timeout_clr), .link_ready(link_ready), .enable_in(enable_in),
    .datapath_en(datapath_en), .dac_valid(dac_valid), .start_pulse(start_pulse),
    .sync_armed(sync_armed), .timeout_err(timeout_err), .state(state)
`ifdef TPL_DAC_SYNC_CNT_EN
    , .sync_count(sync_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm_req = 1'b0; external_sync_en = 1'b0; external_sync = 1'b0;
    sync_delay_cfg = 8'd0; timeout_cfg = 16'd0; timeout_clr = 1'b0;
    link_ready = 1'b1; enable_in = 2'b11;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_dp", datapath_en, 0);
    chk("rst_valid", dac_valid, 0);
    chk("rst_start", start_pulse, 0);
    chk("rst_armed", sync_armed, 0);
    chk("rst_err", timeout_err, 0);
    tick();

    // No external sync, D=0: arm at N -> RUN at N+2.
    pulse_arm();
    chk("t1_n1_state", state, 2);
    chk("t1_n1_start", start_pulse, 0);
    chk("t1_n1_dp", datapath_en, 0);
    tick();
    chk("t1_n2_state", state, 3);
    chk("t1_n2_start", start_pulse, 1);
    chk("t1_n2_dp", datapath_en, 1);
    chk("t1_n2_valid", dac_valid, 0);
    tick();
    chk("t1_n3_start", start_pulse, 0);
    chk("t1_n3_valid", dac_valid, 2'b11);
    chk("t1_n3_dp", datapath_en, 1);

    // External sync, D=5: arm at N, rise at N+20 -> RUN at N+27.
    do_reset();
    external_sync_en = 1'b1; sync_delay_cfg = 8'd5;
    pulse_arm();
    chk("t2_n1_armed", sync_armed, 1);
    chk("t2_n1_state", state, 1);
    chk("t2_n1_dp", datapath_en, 0);
    repeat (19) tick();
    chk("t2_n20_armed", sync_armed, 1);
    external_sync = 1'b1;
    tick();
    chk("t2_n21_state", state, 2);
    chk("t2_n21_armed", sync_armed, 0);
    repeat (5) tick();
    chk("t2_n26_state", state, 2);
    chk("t2_n26_start", start_pulse, 0);
    tick();
    chk("t2_n27_state", state, 3);
    chk("t2_n27_start", start_pulse, 1);

    // Re-arm from RUN with external sync enabled.
    tick();
    chk("t4_valid_pre", dac_valid, 2'b11);
    pulse_arm();
    chk("t4_rearm_state", state, 1);
    chk("t4_rearm_dp", datapath_en, 0);
    chk("t4_rearm_valid", dac_valid, 0);
    external_sync = 1'b0;
    tick();
    external_sync = 1'b1;
    tick();
    chk("t4_m1_state", state, 2);
    repeat (5) tick();
    chk("t4_m6_state", state, 2);
    chk("t4_m6_start", start_pulse, 0);
    tick();
    chk("t4_m7_state", state, 3);
    chk("t4_m7_start", start_pulse, 1);

    // link_ready low for three cycles in RUN.
    tick();
    chk("t5_k_valid", dac_valid, 2'b11);
    link_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) link_ready = 1'b1;
      chk($sformatf("t5_k%0d_valid", i), dac_valid, 0);
      chk($sformatf("t5_k%0d_state", i), state, 3);
      chk($sformatf("t5_k%0d_start", i), start_pulse, 0);
    end
    tick();
    chk("t5_k4_valid", dac_valid, 2'b11);
    enable_in = 2'b01;
    tick();
    tick();
    chk("t5_en01_valid", dac_valid, 2'b01);
    enable_in = 2'b11;

    // Timeout after 100 ARMED cycles; set wins over a concurrent clear.
    do_reset();
    external_sync = 1'b0; timeout_cfg = 16'd100; sync_delay_cfg = 8'd0;
    pulse_arm();
    repeat (99) tick();
    chk("t3_n100_state", state, 1);
    chk("t3_n100_err", timeout_err, 0);
    timeout_clr = 1'b1;
    tick();
    chk("t3_n101_state", state, 0);
    chk("t3_n101_err", timeout_err, 1);
    chk("t3_n101_armed", sync_armed, 0);
    tick();
    timeout_clr = 1'b0;
    chk("t3_clr_err", timeout_err, 0);

    // Rise on the timeout cycle wins.
    pulse_arm();
    repeat (99) tick();
    chk("t3b_n100_state", state, 1);
    external_sync = 1'b1;
    tick();
    chk("t3b_state", state, 2);
    chk("t3b_err", timeout_err, 0);
    tick();
    chk("t3b_run", state, 3);

    // Reset in the middle of a long DELAY.
    do_reset();
    external_sync_en = 1'b0; sync_delay_cfg = 8'd200;
    pulse_arm();
    repeat (3) tick();
    chk("t6_delay_state", state, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_state", state, 0);
    chk("t6_dp", datapath_en, 0);
    chk("t6_valid", dac_valid, 0);
    chk("t6_start", start_pulse, 0);
    chk("t6_armed", sync_armed, 0);
    chk("t6_err", timeout_err, 0);

`ifdef TPL_DAC_SYNC_CNT_EN
    chk("cnt_rst", sync_count, 0);
    sync_delay_cfg = 8'd0;
    for (int i = 0; i < 3; i++) begin
      pulse_arm();
      repeat (2) tick();
    end
    chk("cnt_three", sync_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_sync_ctrl.md
Name: ad_ip_jesd204_tpl_dac_sync_ctrl

Overview:
Sequences start-up of the TPL DAC datapath: arms on a software sync request, optionally waits for an external sync edge, applies a programmable start delay, then releases the datapath. It gates per-channel dac_valid and link-side data, and emits a one-cycle start pulse to reset DDS phase accumulators. It sits between the regmap control bits (sync request, external sync enable, delay/timeout config) and the TPL DAC core, in the link clock domain.

Parameters:
NUM_CHANNELS, 2, number of converter channels; width of enable_in/dac_valid
DELAY_WIDTH, 8, width of sync_delay_cfg and the delay counter
TIMEOUT_WIDTH, 16, width of timeout_cfg and the armed-wait counter

Ports:
clk  input  1  link clock (line-rate/40)
reset  input  1  synchronous, active-high reset
arm_req  input  1  single-cycle sync request from regmap (dac_sync)
external_sync_en  input  1  1 = wait for external_sync edge after arm
external_sync  input  1  external sync, already in clk domain
sync_delay_cfg  input  DELAY_WIDTH  cycles between trigger and release
timeout_cfg  input  TIMEOUT_WIDTH  max cycles in ARMED; 0 = no timeout
timeout_clr  input  1  clears timeout_err
link_ready  input  1  link layer ready
enable_in  input  NUM_CHANNELS  per-channel enables from regmap/DMA
datapath_en  output  1  1 = core may drive link_data; 0 = core forces zero data
dac_valid  output  NUM_CHANNELS  per-channel sample request to DMA
start_pulse  output  1  one cycle high on entry to RUN
sync_armed  output  1  high while in ARMED (dac_external_sync_status)
timeout_err  output  1  sticky: ARMED timed out
state  output  2  current state encoding, for debug/regmap

Behaviour:
- Reset is the only asynchronous-free clear: on reset high at a clk edge → state=IDLE, all outputs 0, counters 0, edge-detect register 0.
- States: IDLE=0, ARMED=1, DELAY=2, RUN=3.
- Edge detect: ext_d registered each cycle; rise = external_sync & ~ext_d. ext_d updates in every state.
- IDLE: datapath_en=0, dac_valid=0. arm_req → ARMED if external_sync_en, else DELAY.
- ARMED: sync_armed=1, outputs gated. Timeout counter cleared on entry and on arm_req, increments each cycle. rise → DELAY. If timeout_cfg≠0 and the counter reaches timeout_cfg → IDLE, timeout_err←1. A rise in the same cycle as a timeout wins (→ DELAY, no error).
- DELAY: the delay counter loads sync_delay_cfg on entry and decrements each cycle. At count 0 → RUN. Latency: a rise sampled at cycle N gives DELAY at N+1 and RUN at N+2+D (D=sync_delay_cfg). Without external sync, an arm_req at N gives RUN at N+2+D.
- RUN: datapath_en=1. dac_valid = enable_in & {NUM_CHANNELS{link_ready}}, registered (1-cycle latency). start_pulse=1 only on the first RUN cycle. Deasserting link_ready does not leave RUN.
- arm_req in DELAY or RUN re-arms: → ARMED or DELAY per external_sync_en, outputs gated from the next cycle, and the delay/timeout counters reload. arm_req in ARMED restarts the timeout only.
- external_sync_en sampled only when arm_req is taken; changing it mid-ARMED has no effect.
- timeout_err: set has priority over timeout_clr in the same cycle.
- Config inputs are static while not IDLE. Delay is sampled at DELAY entry only.

Optional Feature:
TPL_DAC_SYNC_CNT_EN: when defined, adds output sync_count[31:0]. It increments on each RUN entry, saturates at 0xFFFFFFFF, and clears on reset. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, external_sync_en=0, D=0, arm_req at cycle 10 → start_pulse at cycle 12 only; datapath_en=1 from 12; enable_in=2'b11 with link_ready=1 → dac_valid=2'b11 at 13.
- external_sync_en=1, D=5, arm at 10, external_sync rises at 30 → sync_armed 11–30, RUN/start_pulse at 37.
- external_sync_en=1, timeout_cfg=100, no edge → IDLE and timeout_err=1 after 100 ARMED cycles. timeout_clr with no new timeout → 0. Edge on the timeout cycle → DELAY with timeout_err=0.
- In RUN, arm_req with external_sync_en=1 → datapath_en=0 and dac_valid=0 next cycle, state=ARMED; next edge → RUN with a new start_pulse.
- In RUN, link_ready drops for 3 cycles → dac_valid=0 for those cycles (1-cycle lag), state stays RUN, no start_pulse.
- Reset asserted during DELAY (D=200) → next cycle state=IDLE, outputs 0. With TPL_DAC_SYNC_CNT_EN, sync_count=0 after reset and equals 3 after three syncs.
